// File: rtl/stack_cpu_pkg.sv
// rtl/stack_cpu_pkg.sv - shared opcodes, FSM states and opcode classification for the stack CPU front end
package stack_cpu_pkg;

  localparam int CPU_BIT_WIDTH_DEFAULT = 32;

  localparam logic [7:0] OP_NOP  = 8'h00;
  localparam logic [7:0] OP_PUSH = 8'h01;
  localparam logic [7:0] OP_POP  = 8'h02;
  localparam logic [7:0] OP_ADD  = 8'h03;
  localparam logic [7:0] OP_SUB  = 8'h04;
  localparam logic [7:0] OP_DUP  = 8'h05;
  localparam logic [7:0] OP_JMP  = 8'h10;
  localparam logic [7:0] OP_JZ   = 8'h11;
  localparam logic [7:0] OP_HALT = 8'hFF;

  typedef enum logic [2:0] {
    ST_BOOT,
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_WAIT,
    ST_RETIRE,
    ST_HALTED
  } state_t;

  typedef enum logic [1:0] {
    CLS_LOCAL,
    CLS_DISPATCH,
    CLS_HALT,
    CLS_UNDEF
  } op_class_t;

  function automatic op_class_t classify_op(input logic [7:0] op);
    op_class_t cls;
    case (op)
      OP_NOP, OP_JMP:                                   cls = CLS_LOCAL;
      OP_PUSH, OP_POP, OP_ADD, OP_SUB, OP_DUP, OP_JZ:   cls = CLS_DISPATCH;
      OP_HALT:                                          cls = CLS_HALT;
      default:                                          cls = CLS_UNDEF;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/stack_inst_decode.sv
// rtl/stack_inst_decode.sv - combinational opcode decoder: class plus branch/conditional flags
module stack_inst_decode
  import stack_cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output op_class_t  op_class,
  output logic       is_branch,
  output logic       is_cond
);

  always_comb begin
    op_class  = classify_op(opcode);
    is_branch = (opcode == OP_JMP) || (opcode == OP_JZ);
    is_cond   = (opcode == OP_JZ);
  end

endmodule

// File: rtl/stack_inst_frontend.sv
// rtl/stack_inst_frontend.sv - instruction accept/decode/dispatch/retire FSM with program counter
module stack_inst_frontend
  import stack_cpu_pkg::*;
#(
  parameter int CPU_BIT_WIDTH = CPU_BIT_WIDTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [31:0]              inst,
  input  logic                     inst_ready,
  output logic                     inst_complete,
  output logic [CPU_BIT_WIDTH-1:0] pc_next,
  output logic                     exec_start,
  output logic [7:0]               exec_op,
  output logic [CPU_BIT_WIDTH-1:0] exec_imm,
  input  logic                     exec_done,
  input  logic                     exec_zero,
  input  logic                     exec_fault,
  output logic                     halted,
  output logic                     illegal
);

  state_t                   state;
  state_t                   next_state;
  op_class_t                op_class;
  logic                     is_branch;
  logic                     is_cond;
  logic [CPU_BIT_WIDTH-1:0] pc;
  logic [CPU_BIT_WIDTH-1:0] pc_inc;
  logic [CPU_BIT_WIDTH-1:0] branch_target;
  logic [CPU_BIT_WIDTH-1:0] pc_target;

  stack_inst_decode u_decode (
    .opcode    (exec_op),
    .op_class  (op_class),
    .is_branch (is_branch),
    .is_cond   (is_cond)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_BOOT;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_BOOT:   next_state = ST_RETIRE;
      ST_IDLE:   if (inst_ready) next_state = ST_DECODE;
      ST_DECODE: begin
        case (op_class)
          CLS_DISPATCH: next_state = ST_EXEC;
          CLS_HALT:     next_state = ST_HALTED;
          default:      next_state = ST_RETIRE;
        endcase
      end
      // A faulting op is never retired, whether done arrives in EXEC or later.
      ST_EXEC, ST_WAIT: begin
        if (exec_done) begin
          next_state = exec_fault ? ST_HALTED : ST_RETIRE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_RETIRE: next_state = ST_IDLE;
      ST_HALTED: next_state = ST_HALTED;
      default:   next_state = ST_BOOT;
    endcase
  end

  // Branch targets use the raw 24-bit immediate, zero-extended.
  always_comb begin
    pc_inc        = pc + CPU_BIT_WIDTH'(1);
    branch_target = CPU_BIT_WIDTH'(exec_imm[23:0]);
    pc_target     = pc_inc;
    if (state == ST_BOOT) begin
      pc_target = '0;
    end else if (is_branch && (!is_cond || exec_zero)) begin
      pc_target = branch_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc            <= '0;
      pc_next       <= '0;
      exec_op       <= '0;
      exec_imm      <= '0;
      inst_complete <= 1'b0;
      exec_start    <= 1'b0;
      halted        <= 1'b0;
      illegal       <= 1'b0;
    end else begin
      inst_complete <= (next_state == ST_RETIRE);
      exec_start    <= (next_state == ST_EXEC);
      halted        <= (next_state == ST_HALTED);
      if (state == ST_IDLE && inst_ready) begin
        exec_op  <= inst[31:24];
        exec_imm <= CPU_BIT_WIDTH'($signed(inst[23:0]));
      end
      if (state == ST_DECODE && op_class == CLS_UNDEF) begin
        illegal <= 1'b1;
      end
      if (next_state == ST_RETIRE) begin
        pc_next <= pc_target;
      end
      if (state == ST_RETIRE) begin
        pc <= pc_next;
      end
    end
  end

endmodule

// File: tb/tb_stack_inst_frontend.sv
// tb/tb_stack_inst_frontend.sv - directed self-checking bench for stack_inst_frontend
module tb_stack_inst_frontend;

  localparam logic [7:0] T_NOP  = 8'h00;
  localparam logic [7:0] T_PUSH = 8'h01;
  localparam logic [7:0] T_ADD  = 8'h03;
  localparam logic [7:0] T_JMP  = 8'h10;
  localparam logic [7:0] T_JZ   = 8'h11;
  localparam logic [7:0] T_HALT = 8'hFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst;
  logic        inst_ready;
  logic        inst_complete;
  logic [31:0] pc_next;
  logic        exec_start;
  logic [7:0]  exec_op;
  logic [31:0] exec_imm;
  logic        exec_done;
  logic        exec_zero;
  logic        exec_fault;
  logic        halted;
  logic        illegal;

  logic [31:0] inst2;
  logic        inst_ready2;
  logic        inst_complete2;
  logic [23:0] pc_next2;
  logic        exec_start2;
  logic [7:0]  exec_op2;
  logic [23:0] exec_imm2;
  logic        halted2;
  logic        illegal2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_inst_frontend dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst),
    .inst_ready    (inst_ready),
    .inst_complete (inst_complete),
    .pc_next       (pc_next),
    .exec_start    (exec_start),
    .exec_op       (exec_op),
    .exec_imm      (exec_imm),
    .exec_done     (exec_done),
    .exec_zero     (exec_zero),
    .exec_fault    (exec_fault),
    .halted        (halted),
    .illegal       (illegal)
  );

  // Narrow instance so the PC wrap boundary is reachable with a 24-bit jump target.
  stack_inst_frontend #(.CPU_BIT_WIDTH(24)) dut_narrow (
    .clk           (clk),
    .rst_n         (rst_n),
    .inst          (inst2),
    .inst_ready    (inst_ready2),
    .inst_complete (inst_complete2),
    .pc_next       (pc_next2),
    .exec_start    (exec_start2),
    .exec_op       (exec_op2),
    .exec_imm      (exec_imm2),
    .exec_done     (1'b0),
    .exec_zero     (1'b0),
    .exec_fault    (1'b0),
    .halted        (halted2),
    .illegal       (illegal2)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] w);
    @(negedge clk);
    inst = w;
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    inst = '0;
  endtask

  task automatic offer2(input logic [31:0] w);
    @(negedge clk);
    inst2 = w;
    inst_ready2 = 1'b1;
    @(negedge clk);
    inst_ready2 = 1'b0;
    inst2 = '0;
  endtask

  task automatic dispatch(input logic [31:0] w, input int delay, input logic zero, input logic fault);
    offer(w);
    step();
    repeat (delay) step();
    exec_done = 1'b1;
    exec_zero = zero;
    exec_fault = fault;
    step();
    exec_done = 1'b0;
    exec_zero = 1'b0;
    exec_fault = 1'b0;
  endtask

  task automatic do_reset();
    inst_ready = 1'b0;
    inst_ready2 = 1'b0;
    exec_done = 1'b0;
    exec_zero = 1'b0;
    exec_fault = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic seen;
    rst_n = 1'b0;
    step();
    checks++;
    if ({inst_complete, exec_start, halted, illegal, pc_next, exec_op, exec_imm} !== '0) begin
      failures++;
      $display("FAIL reset_values: got complete=%b start=%b halted=%b illegal=%b pc_next=%h op=%h imm=%h, want all 0",
               inst_complete, exec_start, halted, illegal, pc_next, exec_op, exec_imm);
    end
    do_reset();
    step();
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h0) begin
      failures++;
      $display("FAIL boot_retire: got complete=%b pc_next=%h, want 1/00000000", inst_complete, pc_next);
    end
    seen = 1'b0;
    repeat (5) begin
      step();
      if (inst_complete !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL boot_quiet: got extra_complete=%b halted=%b, want 0/0", seen, halted);
    end
  endtask

  task automatic test_nop_push();
    logic early;
    offer({T_NOP, 24'h0});
    checks++;
    if (inst_complete !== 1'b0) begin
      failures++;
      $display("FAIL nop_decode_cycle: got complete=%b, want 0", inst_complete);
    end
    step();
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h1) begin
      failures++;
      $display("FAIL nop_retire: got complete=%b pc_next=%h, want 1/00000001", inst_complete, pc_next);
    end
    offer({T_PUSH, 24'hFFFFFE});
    step();
    checks++;
    if (exec_start !== 1'b1 || exec_op !== 8'h01 || exec_imm !== 32'hFFFFFFFE) begin
      failures++;
      $display("FAIL push_dispatch: got start=%b op=%h imm=%h, want 1/01/fffffffe", exec_start, exec_op, exec_imm);
    end
    early = 1'b0;
    repeat (4) begin
      step();
      if (inst_complete !== 1'b0 || exec_start !== 1'b0) early = 1'b1;
    end
    checks++;
    if (early !== 1'b0) begin
      failures++;
      $display("FAIL push_wait_quiet: got early complete/start=%b, want 0", early);
    end
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h2) begin
      failures++;
      $display("FAIL push_retire: got complete=%b pc_next=%h, want 1/00000002", inst_complete, pc_next);
    end
  endtask

  task automatic test_branch();
    dispatch({T_JZ, 24'h000040}, 0, 1'b1, 1'b0);
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h40) begin
      failures++;
      $display("FAIL jz_taken: got complete=%b pc_next=%h, want 1/00000040", inst_complete, pc_next);
    end
    dispatch({T_JZ, 24'h000040}, 1, 1'b0, 1'b0);
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h41) begin
      failures++;
      $display("FAIL jz_not_taken: got complete=%b pc_next=%h, want 1/00000041", inst_complete, pc_next);
    end
    offer({T_JMP, 24'h000123});
    step();
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h123) begin
      failures++;
      $display("FAIL jmp: got complete=%b pc_next=%h, want 1/00000123", inst_complete, pc_next);
    end
  endtask

  task automatic test_wrap();
    offer2({T_JMP, 24'hFFFFFF});
    step();
    checks++;
    if (inst_complete2 !== 1'b1 || pc_next2 !== 24'hFFFFFF) begin
      failures++;
      $display("FAIL wrap_jmp_max: got complete=%b pc_next=%h, want 1/ffffff", inst_complete2, pc_next2);
    end
    offer2({T_JMP, 24'h000000});
    step();
    checks++;
    if (inst_complete2 !== 1'b1 || pc_next2 !== 24'h0) begin
      failures++;
      $display("FAIL wrap_jmp_zero: got complete=%b pc_next=%h, want 1/000000", inst_complete2, pc_next2);
    end
    offer2({T_JMP, 24'hFFFFFF});
    step();
    offer2({T_NOP, 24'h0});
    step();
    checks++;
    if (inst_complete2 !== 1'b1 || pc_next2 !== 24'h0) begin
      failures++;
      $display("FAIL wrap_nop: got complete=%b pc_next=%h, want 1/000000", inst_complete2, pc_next2);
    end
  endtask

  task automatic test_illegal();
    offer(32'h7E000000);
    step();
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h124 || illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_retire: got complete=%b pc_next=%h illegal=%b, want 1/00000124/1",
               inst_complete, pc_next, illegal);
    end
    offer({T_PUSH, 24'h000005});
    step();
    step();
    inst = {T_HALT, 24'h0};
    inst_ready = 1'b1;
    step();
    step();
    inst_ready = 1'b0;
    inst = '0;
    exec_done = 1'b1;
    step();
    exec_done = 1'b0;
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h125 || exec_op !== 8'h01 || halted !== 1'b0) begin
      failures++;
      $display("FAIL ready_in_wait_ignored: got complete=%b pc_next=%h op=%h halted=%b, want 1/00000125/01/0",
               inst_complete, pc_next, exec_op, halted);
    end
    checks++;
    if (illegal !== 1'b1) begin
      failures++;
      $display("FAIL illegal_sticky: got %b, want 1", illegal);
    end
  endtask

  task automatic test_halt();
    logic seen;
    offer({T_HALT, 24'h0});
    step();
    checks++;
    if (halted !== 1'b1 || inst_complete !== 1'b0) begin
      failures++;
      $display("FAIL halt_enter: got halted=%b complete=%b, want 1/0", halted, inst_complete);
    end
    seen = 1'b0;
    repeat (3) begin
      offer({T_NOP, 24'h0});
      step();
      if (inst_complete !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_absorbing: got complete_seen=%b halted=%b, want 0/1", seen, halted);
    end
  endtask

  task automatic test_fault();
    logic seen;
    do_reset();
    step();
    dispatch({T_ADD, 24'h0}, 2, 1'b0, 1'b1);
    checks++;
    if (halted !== 1'b1 || inst_complete !== 1'b0) begin
      failures++;
      $display("FAIL fault_halt: got halted=%b complete=%b, want 1/0", halted, inst_complete);
    end
    seen = 1'b0;
    repeat (3) begin
      offer({T_NOP, 24'h0});
      step();
      if (inst_complete !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL fault_no_retire: got complete_seen=%b, want 0", seen);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step();
    offer({T_NOP, 24'h0});
    step();
    offer({T_PUSH, 24'h000010});
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({inst_complete, exec_start, halted, illegal, pc_next, exec_op, exec_imm} !== '0) begin
      failures++;
      $display("FAIL async_reset_clear: got complete=%b start=%b halted=%b illegal=%b pc_next=%h op=%h imm=%h, want all 0",
               inst_complete, exec_start, halted, illegal, pc_next, exec_op, exec_imm);
    end
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (inst_complete !== 1'b1 || pc_next !== 32'h0 || halted !== 1'b0) begin
      failures++;
      $display("FAIL boot_replay: got complete=%b pc_next=%h halted=%b, want 1/00000000/0",
               inst_complete, pc_next, halted);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    inst = '0;
    inst_ready = 1'b0;
    inst2 = '0;
    inst_ready2 = 1'b0;
    exec_done = 1'b0;
    exec_zero = 1'b0;
    exec_fault = 1'b0;
    test_reset();
    test_nop_push();
    test_branch();
    test_wrap();
    test_illegal();
    test_halt();
    test_fault();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
